bus_drv_fifo_bank: RTL and testbench

// Synthesizable multi-channel transmit FIFO bank on the device side of bs_gnrtr_n_rbtr.
// One FIFO per bus driver port. Each channel is written by the agent side and popped by the bus

---
 rtl/bus_drv_fifo_bank_pkg.sv | 14 +
 rtl/bus_drv_fifo_bank_if.sv | 33 +++
 rtl/bus_drv_fifo_bank_ch.sv | 107 ++++++++++
 rtl/bus_drv_fifo_bank.sv | 37 +++
 tb/tb_bus_drv_fifo_bank.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_drv_fifo_bank_pkg.sv
// Shared types and helpers for the bus driver transmit FIFO bank.
package bus_fifo_pkg;

    typedef enum logic {
        DROP_NEW      = 1'b0,
        OVERWRITE_OLD = 1'b1
    } ovf_mode_e;

    // Width of an occupancy counter able to hold 0..depth.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/bus_drv_fifo_bank_if.sv
// Agent/bus side signal bundle of the FIFO bank, one lane per driver port.
interface bus_drv_fifo_bank_if
    import bus_fifo_pkg::*;
#(
    parameter int pckg_sz   = 16,
    parameter int deep_fifo = 8,
    parameter int drvrs     = 4
);
    localparam int CW = cnt_w(deep_fifo);

    logic [drvrs-1:0]              flush;
    logic [drvrs-1:0]              wr_en;
    logic [drvrs-1:0][pckg_sz-1:0] wr_data;
    logic [drvrs-1:0]              full;
    logic [drvrs-1:0]              pop;
    logic [drvrs-1:0][pckg_sz-1:0] D_pop;
    logic [drvrs-1:0]              pndng;
    logic [drvrs-1:0][CW-1:0]      count;
    logic [drvrs-1:0]              ovf_err;
    logic [drvrs-1:0]              udf_err;
    logic                          err_clr;

    modport master (
        output flush, wr_en, wr_data, pop, err_clr,
        input  full, D_pop, pndng, count, ovf_err, udf_err
    );

    modport slave (
        input  flush, wr_en, wr_data, pop, err_clr,
        output full, D_pop, pndng, count, ovf_err, udf_err
    );

endinterface

// File: rtl/bus_drv_fifo_bank_ch.sv
// One FWFT transmit FIFO channel: storage, pointers, occupancy and sticky error flags.
module bus_drv_fifo_ch
    import bus_fifo_pkg::*;
#(
    parameter int        pckg_sz   = 16,
    parameter int        deep_fifo = 8,
    parameter ovf_mode_e OVF_MODE  = DROP_NEW,
    localparam int       CW        = cnt_w(deep_fifo)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               wr_en,
    input  logic [pckg_sz-1:0] wr_data,
    input  logic               pop,
    input  logic               err_clr,
    output logic               full,
    output logic               pndng,
    output logic [pckg_sz-1:0] d_pop,
    output logic [CW-1:0]      count,
    output logic               ovf_err,
    output logic               udf_err
);
    localparam int PW = $clog2(deep_fifo);

    logic [pckg_sz-1:0] mem [deep_fifo];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic               empty;
    logic               at_full;
    logic               do_pop;
    logic               do_wr;
    logic               rd_adv;
    logic               ovf_evt;
    logic               udf_evt;

    // Pointer increment with explicit wrap, so depth need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(deep_fifo - 1)) ? '0 : p + 1'b1;
    endfunction

    // Decode this cycle's actions; flush masks all push/pop activity and error events.
    always_comb begin
        empty   = (count == '0);
        at_full = (count == CW'(deep_fifo));
        udf_evt = pop && empty && !flush;
        ovf_evt = wr_en && at_full && !pop && !flush;
        do_pop  = pop && !empty && !flush;
        do_wr   = wr_en && !flush && (!at_full || pop || (OVF_MODE == OVERWRITE_OLD));
        // Overwrite at full drags the read pointer along, dropping the oldest entry.
        rd_adv  = do_pop || (do_wr && at_full && !pop);
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and sticky flags; a set event beats err_clr.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_wr) begin
                    wr_ptr <= ptr_inc(wr_ptr);
                end
                if (rd_adv) begin
                    rd_ptr <= ptr_inc(rd_ptr);
                end
                if (do_wr && !rd_adv) begin
                    count <= count + 1'b1;
                end else if (!do_wr && rd_adv) begin
                    count <= count - 1'b1;
                end
            end
            if (ovf_evt) begin
                ovf_err <= 1'b1;
            end else if (err_clr) begin
                ovf_err <= 1'b0;
            end
            if (udf_evt) begin
                udf_err <= 1'b1;
            end else if (err_clr) begin
                udf_err <= 1'b0;
            end
        end
    end

    // Status and head data derive only from registered state.
    always_comb begin
        full  = at_full;
        pndng = !empty;
        d_pop = empty ? '0 : mem[rd_ptr];
    end

endmodule

// File: rtl/bus_drv_fifo_bank.sv
// Multi-channel transmit FIFO bank: one independent channel per bus driver port.
module bus_drv_fifo_bank
    import bus_fifo_pkg::*;
#(
    parameter int        pckg_sz   = 16,
    parameter int        deep_fifo = 8,
    parameter int        drvrs     = 4,
    parameter ovf_mode_e OVF_MODE  = DROP_NEW
) (
    input  logic                clk,
    input  logic                reset,
    bus_drv_fifo_bank_if.slave  bus
);

    for (genvar i = 0; i < drvrs; i++) begin : g_ch
        bus_drv_fifo_ch #(
            .pckg_sz   (pckg_sz),
            .deep_fifo (deep_fifo),
            .OVF_MODE  (OVF_MODE)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .flush   (bus.flush[i]),
            .wr_en   (bus.wr_en[i]),
            .wr_data (bus.wr_data[i]),
            .pop     (bus.pop[i]),
            .err_clr (bus.err_clr),
            .full    (bus.full[i]),
            .pndng   (bus.pndng[i]),
            .d_pop   (bus.D_pop[i]),
            .count   (bus.count[i]),
            .ovf_err (bus.ovf_err[i]),
            .udf_err (bus.udf_err[i])
        );
    end

endmodule

// File: tb/tb_bus_drv_fifo_bank.sv
// Bench for bus_drv_fifo_bank: both overflow modes driven in lockstep against a queue model.
module tb_bus_drv_fifo_bank;
    import bus_fifo_pkg::*;

    localparam int PW    = 16;
    localparam int DEPTH = 8;
    localparam int NCH   = 4;
    localparam int CW    = cnt_w(DEPTH);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      reset_v;
    logic [NCH-1:0]            flush_v;
    logic [NCH-1:0]            wr_v;
    logic [NCH-1:0]            pop_v;
    logic [NCH-1:0][PW-1:0]    wd_v;
    logic                      clr_v;

    int tests = 0;
    int fails = 0;

    // Reference state: one queue and two flags per channel per overflow mode.
    logic [PW-1:0] mq [2][NCH][$];
    bit            m_ovf [2][NCH];
    bit            m_udf [2][NCH];

    bus_drv_fifo_bank_if #(.pckg_sz(PW), .deep_fifo(DEPTH), .drvrs(NCH)) if0 ();
    bus_drv_fifo_bank_if #(.pckg_sz(PW), .deep_fifo(DEPTH), .drvrs(NCH)) if1 ();

    assign if0.flush   = flush_v;
    assign if0.wr_en   = wr_v;
    assign if0.wr_data = wd_v;
    assign if0.pop     = pop_v;
    assign if0.err_clr = clr_v;
    assign if1.flush   = flush_v;
    assign if1.wr_en   = wr_v;
    assign if1.wr_data = wd_v;
    assign if1.pop     = pop_v;
    assign if1.err_clr = clr_v;

    bus_drv_fifo_bank #(
        .pckg_sz(PW), .deep_fifo(DEPTH), .drvrs(NCH), .OVF_MODE(DROP_NEW)
    ) dut0 (
        .clk(clk), .reset(reset_v), .bus(if0)
    );

    bus_drv_fifo_bank #(
        .pckg_sz(PW), .deep_fifo(DEPTH), .drvrs(NCH), .OVF_MODE(OVERWRITE_OLD)
    ) dut1 (
        .clk(clk), .reset(reset_v), .bus(if1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        flush_v = '0;
        wr_v    = '0;
        pop_v   = '0;
        wd_v    = '0;
        clr_v   = 1'b0;
    endtask

    // Apply the current inputs to the model as one clock edge.
    task automatic model_edge();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < NCH; i++) begin
                bit ovf_e;
                bit udf_e;
                ovf_e = 1'b0;
                udf_e = 1'b0;
                if (!reset_v) begin
                    mq[m][i].delete();
                    m_ovf[m][i] = 1'b0;
                    m_udf[m][i] = 1'b0;
                end else begin
                    if (flush_v[i]) begin
                        mq[m][i].delete();
                    end else begin
                        udf_e = pop_v[i] && (mq[m][i].size() == 0);
                        ovf_e = wr_v[i] && !pop_v[i] && (mq[m][i].size() == DEPTH);
                        if (pop_v[i] && mq[m][i].size() > 0) void'(mq[m][i].pop_front());
                        if (wr_v[i]) begin
                            if (mq[m][i].size() < DEPTH) begin
                                mq[m][i].push_back(wd_v[i]);
                            end else if (m == 1) begin
                                void'(mq[m][i].pop_front());
                                mq[m][i].push_back(wd_v[i]);
                            end
                        end
                    end
                    m_ovf[m][i] = ovf_e ? 1'b1 : (clr_v ? 1'b0 : m_ovf[m][i]);
                    m_udf[m][i] = udf_e ? 1'b1 : (clr_v ? 1'b0 : m_udf[m][i]);
                end
            end
        end
    endtask

    task automatic check_all();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < NCH; i++) begin
                logic [PW-1:0] od;
                logic [CW-1:0] oc;
                logic of, op, oo, ou;
                logic [PW-1:0] ed;
                int sz;
                if (m == 0) begin
                    od = if0.D_pop[i]; oc = if0.count[i]; of = if0.full[i];
                    op = if0.pndng[i]; oo = if0.ovf_err[i]; ou = if0.udf_err[i];
                end else begin
                    od = if1.D_pop[i]; oc = if1.count[i]; of = if1.full[i];
                    op = if1.pndng[i]; oo = if1.ovf_err[i]; ou = if1.udf_err[i];
                end
                sz = mq[m][i].size();
                ed = (sz > 0) ? mq[m][i][0] : '0;
                chk($sformatf("m%0d_ch%0d_dpop", m, i), 32'(od), 32'(ed));
                chk($sformatf("m%0d_ch%0d_count", m, i), 32'(oc), 32'(sz));
                chk($sformatf("m%0d_ch%0d_full", m, i), 32'(of), 32'(sz == DEPTH));
                chk($sformatf("m%0d_ch%0d_pndng", m, i), 32'(op), 32'(sz != 0));
                chk($sformatf("m%0d_ch%0d_ovf", m, i), 32'(oo), 32'(m_ovf[m][i]));
                chk($sformatf("m%0d_ch%0d_udf", m, i), 32'(ou), 32'(m_udf[m][i]));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        reset_v = 1'b0;
        idle();
        tick();
        tick();
        reset_v = 1'b1;

        // Reset mid-stream with ch0 holding five entries.
        for (int k = 0; k < 5; k++) begin
            idle(); wr_v[0] = 1'b1; wd_v[0] = PW'(k + 1);
            tick();
        end
        idle();
        reset_v = 1'b0;
        #1;
        model_edge();
        check_all();
        chk("async_rst_count0", 32'(if0.count[0]), 32'd0);
        tick();
        reset_v = 1'b1;
        wr_v[0] = 1'b1; wd_v[0] = 16'h0102;
        tick();
        idle();
        chk("post_rst_dpop0", 32'(if0.D_pop[0]), 32'h0102);
        chk("post_rst_pndng0", 32'(if0.pndng[0]), 32'd1);
        pop_v[0] = 1'b1;
        tick();
        idle();

        // Fill and drain ch1 twice to cross the pointer wrap.
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 1; k <= DEPTH; k++) begin
                idle(); wr_v[1] = 1'b1; wd_v[1] = PW'(pass * DEPTH + k);
                tick();
            end
            idle();
            chk("fill_full1", 32'(if0.full[1]), 32'd1);
            for (int k = 0; k < DEPTH; k++) begin
                pop_v[1] = 1'b1;
                tick();
            end
            idle();
            chk("drain_pndng1", 32'(if0.pndng[1]), 32'd0);
        end

        // Overflow on ch2 in both modes.
        for (int k = 1; k <= DEPTH + 1; k++) begin
            idle(); wr_v[2] = 1'b1; wd_v[2] = PW'(k);
            tick();
        end
        idle();
        chk("ovf_m0_flag2", 32'(if0.ovf_err[2]), 32'd1);
        chk("ovf_m1_flag2", 32'(if1.ovf_err[2]), 32'd1);
        chk("ovf_m0_head2", 32'(if0.D_pop[2]), 32'd1);
        chk("ovf_m1_head2", 32'(if1.D_pop[2]), 32'd2);
        for (int k = 0; k < DEPTH; k++) begin
            pop_v[2] = 1'b1;
            tick();
        end
        idle();

        // Write+pop at full, then pop+write on empty, on ch3.
        for (int k = 1; k <= DEPTH; k++) begin
            idle(); wr_v[3] = 1'b1; wd_v[3] = PW'(k);
            tick();
        end
        idle(); wr_v[3] = 1'b1; wd_v[3] = 16'd9; pop_v[3] = 1'b1;
        tick();
        idle();
        chk("full_wp_dpop3", 32'(if0.D_pop[3]), 32'd2);
        chk("full_wp_count3", 32'(if0.count[3]), 32'd8);
        chk("full_wp_ovf3", 32'(if0.ovf_err[3]), 32'd0);
        for (int k = 0; k < DEPTH; k++) begin
            pop_v[3] = 1'b1;
            tick();
        end
        idle(); wr_v[3] = 1'b1; wd_v[3] = 16'd5; pop_v[3] = 1'b1;
        tick();
        idle();
        chk("empty_pw_udf3", 32'(if0.udf_err[3]), 32'd1);
        chk("empty_pw_dpop3", 32'(if0.D_pop[3]), 32'd5);
        chk("empty_pw_count3", 32'(if0.count[3]), 32'd1);

        // Clear with no error event present.
        clr_v = 1'b1;
        tick();
        idle();

        // Flush ch0 at count 4 with a same-cycle pop and write; ch2 holds data alongside.
        for (int k = 1; k <= 4; k++) begin
            idle(); wr_v[0] = 1'b1; wd_v[0] = PW'(16'h40 + k);
            wr_v[2] = 1'b1; wd_v[2] = PW'(16'h20 + k);
            tick();
        end
        idle(); flush_v[0] = 1'b1; pop_v[0] = 1'b1; wr_v[0] = 1'b1; wd_v[0] = 16'hBEEF;
        tick();
        idle();
        chk("flush_count0", 32'(if0.count[0]), 32'd0);
        chk("flush_udf0", 32'(if0.udf_err[0]), 32'd0);

        // Set beats clear on the same cycle.
        pop_v[1] = 1'b1;
        tick();
        pop_v[1] = 1'b1; clr_v = 1'b1;
        tick();
        idle();
        chk("clr_vs_set_udf1", 32'(if0.udf_err[1]), 32'd1);
        clr_v = 1'b1;
        tick();
        idle();

        // Randomised traffic on all channels.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NCH; i++) begin
                wr_v[i]    = ($urandom_range(0, 99) < 55);
                pop_v[i]   = ($urandom_range(0, 99) < 45);
                flush_v[i] = ($urandom_range(0, 99) < 3);
                wd_v[i]    = PW'($urandom);
            end
            clr_v = ($urandom_range(0, 99) < 4);
            tick();
        end
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
